// File: rtl/delay_pkg.sv
// Shared delay-path package: default SRAM geometry, strobe counter width,
// and the SRAM controller state / last-served encodings.
package delay_pkg;

    localparam int SRAM_DATA_WIDTH_DEF  = 16;
    localparam int SRAM_ADDR_WIDTH_DEF  = 12;
    localparam int SRAM_CAPACITY_DEF    = 4096;
    localparam int SRAM_WAIT_CYCLES_DEF = 2;

    // Wide enough for the largest legal strobe length (15).
    localparam int STROBE_CNT_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_READ_STROBE  = 3'd1,
        ST_WRITE_SETUP  = 3'd2,
        ST_WRITE_STROBE = 3'd3,
        ST_WRITE_HOLD   = 3'd4,
        ST_RECOVER      = 3'd5
    } sram_state_e;

    typedef enum logic {
        SERVED_READ  = 1'b0,
        SERVED_WRITE = 1'b1
    } served_e;

    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] capacity);
        return addr < capacity;
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Requester-side bus of the SRAM controller: level requests, addresses,
// write data, registered read data and single-cycle response pulses.
interface sram_ctrl_if
    import delay_pkg::*;
#(
    parameter int data_width      = SRAM_DATA_WIDTH_DEF,
    parameter int sram_addr_width = SRAM_ADDR_WIDTH_DEF
) ();

    // Handshake: a requester raises req_* (with its address/data) and holds
    // it unchanged until exactly one of the matching ready/invalid pulses is
    // seen; the controller samples only when idle and pulses each for 1 cycle.
    logic                       req_sram_read;
    logic                       req_sram_write;
    logic [sram_addr_width-1:0] req_sram_read_addr;
    logic [sram_addr_width-1:0] req_sram_write_addr;
    logic [data_width-1:0]      data_to_sram;
    logic [data_width-1:0]      data_from_sram;
    logic                       sram_read_ready;
    logic                       sram_write_ready;
    logic                       sram_read_invalid;
    logic                       sram_write_invalid;

    modport master (
        output req_sram_read, req_sram_write,
        output req_sram_read_addr, req_sram_write_addr, data_to_sram,
        input  data_from_sram,
        input  sram_read_ready, sram_write_ready,
        input  sram_read_invalid, sram_write_invalid
    );

    modport slave (
        input  req_sram_read, req_sram_write,
        input  req_sram_read_addr, req_sram_write_addr, data_to_sram,
        output data_from_sram,
        output sram_read_ready, sram_write_ready,
        output sram_read_invalid, sram_write_invalid
    );

endinterface

// File: rtl/sram_req_arbiter.sv
// Combinational read/write request arbiter. Reads win by default;
// with SRAM_CTRL_RR_EN defined, simultaneous requests alternate on last_served.
module sram_req_arbiter
    import delay_pkg::*;
(
    input  logic    req_read,
    input  logic    req_write,
    input  served_e last_served,
    output logic    grant_read,
    output logic    grant_write
);

`ifdef SRAM_CTRL_RR_EN
    always_comb begin
        grant_read  = req_read  && (!req_write || (last_served == SERVED_WRITE));
        grant_write = req_write && (!req_read  || (last_served == SERVED_READ));
    end
`else
    // Fixed priority: the served history is deliberately ignored.
    served_e unused_last_served;
    assign unused_last_served = last_served;

    always_comb begin
        grant_read  = req_read;
        grant_write = req_write && !req_read;
    end
`endif

endmodule

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller with strobed read/write cycles and fully
// registered outputs. SRAM_CTRL_RR_EN selects round-robin arbitration.
module sram_ctrl
    import delay_pkg::*;
#(
    parameter int data_width      = SRAM_DATA_WIDTH_DEF,
    parameter int sram_addr_width = SRAM_ADDR_WIDTH_DEF,
    parameter int sram_capacity   = SRAM_CAPACITY_DEF,
    parameter int wait_cycles     = SRAM_WAIT_CYCLES_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    sram_ctrl_if.slave                 req_if,
    output logic [sram_addr_width-1:0] sram_a,
    output logic [data_width-1:0]      sram_dq_o,
    input  logic [data_width-1:0]      sram_dq_i,
    output logic                       sram_dq_oe,
    output logic                       sram_ce_n,
    output logic                       sram_oe_n,
    output logic                       sram_we_n,
    output logic                       busy,
    output sram_state_e                state_o
);

    localparam int              CW       = STROBE_CNT_WIDTH;
    localparam logic [CW-1:0]   CNT_LAST = CW'(wait_cycles - 1);
    localparam logic [31:0]     CAPACITY = 32'(sram_capacity);

    sram_state_e                state_q, state_d;
    served_e                    last_served_q, last_served_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [sram_addr_width-1:0] a_q, a_d;
    logic [data_width-1:0]      dq_o_q, dq_o_d;
    logic [data_width-1:0]      rdata_q, rdata_d;
    logic                       dq_oe_q, dq_oe_d;
    logic                       ce_n_q, ce_n_d;
    logic                       oe_n_q, oe_n_d;
    logic                       we_n_q, we_n_d;
    logic                       rd_rdy_q, rd_rdy_d;
    logic                       wr_rdy_q, wr_rdy_d;
    logic                       rd_inv_q, rd_inv_d;
    logic                       wr_inv_q, wr_inv_d;
    logic                       busy_q, busy_d;

    logic grant_read, grant_write;
    logic read_addr_ok, write_addr_ok;

    sram_req_arbiter u_arb (
        .req_read    (req_if.req_sram_read),
        .req_write   (req_if.req_sram_write),
        .last_served (last_served_q),
        .grant_read  (grant_read),
        .grant_write (grant_write)
    );

    assign read_addr_ok  = addr_in_range(32'(req_if.req_sram_read_addr), CAPACITY);
    assign write_addr_ok = addr_in_range(32'(req_if.req_sram_write_addr), CAPACITY);

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        cnt_d         = cnt_q;
        a_d           = a_q;
        dq_o_d        = dq_o_q;
        rdata_d       = rdata_q;
        dq_oe_d       = dq_oe_q;
        ce_n_d        = ce_n_q;
        oe_n_d        = oe_n_q;
        we_n_d        = we_n_q;
        rd_rdy_d      = 1'b0;
        wr_rdy_d      = 1'b0;
        rd_inv_d      = 1'b0;
        wr_inv_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_read) begin
                    last_served_d = SERVED_READ;
                    if (read_addr_ok) begin
                        a_d     = req_if.req_sram_read_addr;
                        ce_n_d  = 1'b0;
                        oe_n_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_READ_STROBE;
                    end else begin
                        rd_inv_d = 1'b1;
                        state_d  = ST_RECOVER;
                    end
                end else if (grant_write) begin
                    last_served_d = SERVED_WRITE;
                    if (write_addr_ok) begin
                        a_d     = req_if.req_sram_write_addr;
                        dq_o_d  = req_if.data_to_sram;
                        dq_oe_d = 1'b1;
                        ce_n_d  = 1'b0;
                        we_n_d  = 1'b1;
                        state_d = ST_WRITE_SETUP;
                    end else begin
                        wr_inv_d = 1'b1;
                        state_d  = ST_RECOVER;
                    end
                end
            end
            ST_READ_STROBE: begin
                if (cnt_q == CNT_LAST) begin
                    rdata_d  = sram_dq_i;
                    rd_rdy_d = 1'b1;
                    ce_n_d   = 1'b1;
                    oe_n_d   = 1'b1;
                    state_d  = ST_RECOVER;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WRITE_SETUP: begin
                we_n_d  = 1'b0;
                cnt_d   = '0;
                state_d = ST_WRITE_STROBE;
            end
            ST_WRITE_STROBE: begin
                if (cnt_q == CNT_LAST) begin
                    we_n_d  = 1'b1;
                    state_d = ST_WRITE_HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WRITE_HOLD: begin
                // Data stays driven through the hold cycle after we_n rises.
                dq_oe_d  = 1'b0;
                ce_n_d   = 1'b1;
                wr_rdy_d = 1'b1;
                state_d  = ST_RECOVER;
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            last_served_q <= SERVED_WRITE;
            cnt_q         <= '0;
            a_q           <= '0;
            dq_o_q        <= '0;
            rdata_q       <= '0;
            dq_oe_q       <= 1'b0;
            ce_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
            we_n_q        <= 1'b1;
            rd_rdy_q      <= 1'b0;
            wr_rdy_q      <= 1'b0;
            rd_inv_q      <= 1'b0;
            wr_inv_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            cnt_q         <= cnt_d;
            a_q           <= a_d;
            dq_o_q        <= dq_o_d;
            rdata_q       <= rdata_d;
            dq_oe_q       <= dq_oe_d;
            ce_n_q        <= ce_n_d;
            oe_n_q        <= oe_n_d;
            we_n_q        <= we_n_d;
            rd_rdy_q      <= rd_rdy_d;
            wr_rdy_q      <= wr_rdy_d;
            rd_inv_q      <= rd_inv_d;
            wr_inv_q      <= wr_inv_d;
            busy_q        <= busy_d;
        end
    end

    assign sram_a                    = a_q;
    assign sram_dq_o                 = dq_o_q;
    assign sram_dq_oe                = dq_oe_q;
    assign sram_ce_n                 = ce_n_q;
    assign sram_oe_n                 = oe_n_q;
    assign sram_we_n                 = we_n_q;
    assign busy                      = busy_q;
    assign state_o                   = state_q;
    assign req_if.data_from_sram     = rdata_q;
    assign req_if.sram_read_ready    = rd_rdy_q;
    assign req_if.sram_write_ready   = wr_rdy_q;
    assign req_if.sram_read_invalid  = rd_inv_q;
    assign req_if.sram_write_invalid = wr_inv_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: behavioural SRAM, response scoreboard,
// directed and random accesses. Honours SRAM_CTRL_RR_EN for expected order.
`timescale 1ns/1ps
module tb_sram_ctrl;
  import delay_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 13;
  localparam int CAP = 4096;
  localparam int WC  = 2;
  localparam int MAX_WAIT = 64;
`ifdef SRAM_CTRL_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  localparam logic [3:0] K_RRDY = 4'd1;
  localparam logic [3:0] K_WRDY = 4'd2;
  localparam logic [3:0] K_RINV = 4'd3;
  localparam logic [3:0] K_WINV = 4'd4;
  localparam logic [3:0] K_NONE = 4'hF;

  localparam logic [AW-1:0] CR_ADDR = 13'h010;
  localparam logic [AW-1:0] CW_ADDR = 13'h020;
  localparam logic [DW-1:0] CW_DATA = 16'hC0DE;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_dq_o;
  logic [DW-1:0] sram_dq_i;
  logic          sram_dq_oe;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic          busy;
  sram_state_e   state_o;

  sram_ctrl_if #(.data_width(DW), .sram_addr_width(AW)) bus ();

  sram_ctrl #(
    .data_width(DW), .sram_addr_width(AW), .sram_capacity(CAP), .wait_cycles(WC)
  ) dut (
    .clk(clk), .reset(reset), .req_if(bus),
    .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .busy(busy), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // ---------------- SRAM model ----------------
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_a] : '0;

  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_a] = sram_dq_o;
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [3:0]    kind_q[$];
  int n_vec = 0;
  int n_err = 0;
  int n_rd_rdy = 0, n_wr_rdy = 0, n_ce_fall = 0, n_we_low = 0, n_dq_oe = 0;
  logic prev_ce_n = 1'b1;
  served_e exp_last = SERVED_WRITE;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic score(input logic [3:0] got);
    if (kind_q.size() == 0) check("unexpected_response", 32'(got), 32'(K_NONE));
    else check("response_kind", 32'(got), 32'(kind_q.pop_front()));
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (!sram_ce_n) begin
        check("dq_oe_while_oe_n_low", 32'(!sram_oe_n && sram_dq_oe), 32'd0);
        check("oe_n_and_we_n_low", 32'(!sram_oe_n && !sram_we_n), 32'd0);
      end
      if (prev_ce_n && !sram_ce_n) n_ce_fall++;
      if (!sram_we_n) n_we_low++;
      if (sram_dq_oe) n_dq_oe++;
      if (bus.sram_read_ready) begin
        n_rd_rdy++;
        score(K_RRDY);
        if (exp_q.size() != 0) check("read_data", 32'(bus.data_from_sram), 32'(exp_q.pop_front()));
      end
      if (bus.sram_write_ready) begin
        n_wr_rdy++;
        score(K_WRDY);
      end
      if (bus.sram_read_invalid) score(K_RINV);
      if (bus.sram_write_invalid) score(K_WINV);
    end
    prev_ce_n = sram_ce_n;
  end

  // ---------------- driver tasks ----------------
  function automatic logic any_resp();
    return bus.sram_read_ready | bus.sram_write_ready |
           bus.sram_read_invalid | bus.sram_write_invalid;
  endfunction

  task automatic wait_resp(output int n_edges);
    n_edges = 0;
    while (!any_resp() && n_edges < MAX_WAIT) begin
      @(posedge clk); #1;
      n_edges++;
    end
    check("response_timeout", 32'(n_edges < MAX_WAIT), 32'd1);
  endtask

  // Holds the request through the response cycle and drops it one edge later.
  task automatic run_access(input bit is_wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bit    valid;
    int    n_edges;
    int    exp_edges;
    string tag;
    valid = (int'(addr) < CAP);
    if (is_wr) begin
      tag = "write_latency";
      exp_last = SERVED_WRITE;
      if (valid) begin
        kind_q.push_back(K_WRDY);
        exp_mem[addr] = data;
        exp_edges = WC + 2;
      end else begin
        kind_q.push_back(K_WINV);
        exp_edges = 0;
      end
      bus.req_sram_write_addr = addr;
      bus.data_to_sram = data;
      bus.req_sram_write = 1'b1;
    end else begin
      tag = "read_latency";
      exp_last = SERVED_READ;
      if (valid) begin
        kind_q.push_back(K_RRDY);
        exp_q.push_back(exp_mem[addr]);
        exp_edges = WC;
      end else begin
        kind_q.push_back(K_RINV);
        exp_edges = 0;
      end
      bus.req_sram_read_addr = addr;
      bus.req_sram_read = 1'b1;
    end
    @(posedge clk); #1;
    wait_resp(n_edges);
    check(tag, 32'(n_edges), 32'(exp_edges));
    check("recover_in_resp_cycle", 32'(state_o), 32'(ST_RECOVER));
    @(posedge clk); #1;
    bus.req_sram_read = 1'b0;
    bus.req_sram_write = 1'b0;
    check("idle_after_one_recover", 32'(state_o), 32'(ST_IDLE));
  endtask

  // Both requests held continuously for n accesses.
  task automatic run_contend(input int n);
    int n_edges;
    for (int k = 0; k < n; k++) begin
      if (RR_EN && exp_last == SERVED_READ) begin
        kind_q.push_back(K_WRDY);
        exp_mem[CW_ADDR] = CW_DATA;
        exp_last = SERVED_WRITE;
      end else begin
        kind_q.push_back(K_RRDY);
        exp_q.push_back(exp_mem[CR_ADDR]);
        exp_last = SERVED_READ;
      end
    end
    bus.req_sram_read_addr = CR_ADDR;
    bus.req_sram_write_addr = CW_ADDR;
    bus.data_to_sram = CW_DATA;
    bus.req_sram_read = 1'b1;
    bus.req_sram_write = 1'b1;
    for (int k = 0; k < n; k++) begin
      wait_resp(n_edges);
      @(posedge clk); #1;
    end
    bus.req_sram_read = 1'b0;
    bus.req_sram_write = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [DW-1:0] v;
    int s0, s1, s2, t;

    for (int i = 0; i < (1 << AW); i++) begin
      v = DW'(i * 37) ^ 16'h5A5A;
      mem[i] = v;
      exp_mem[i] = v;
    end
    mem[CR_ADDR] = 16'hBEEF;
    exp_mem[CR_ADDR] = 16'hBEEF;

    bus.req_sram_read = 1'b0;
    bus.req_sram_write = 1'b0;
    bus.req_sram_read_addr = '0;
    bus.req_sram_write_addr = '0;
    bus.data_to_sram = '0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sram_a", 32'(sram_a), 32'd0);
    check("rst_dq_o", 32'(sram_dq_o), 32'd0);
    check("rst_data_from_sram", 32'(bus.data_from_sram), 32'd0);
    check("rst_ce_n", 32'(sram_ce_n), 32'd1);
    check("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_read_ready", 32'(bus.sram_read_ready), 32'd0);
    check("rst_write_ready", 32'(bus.sram_write_ready), 32'd0);
    check("rst_read_invalid", 32'(bus.sram_read_invalid), 32'd0);
    check("rst_write_invalid", 32'(bus.sram_write_invalid), 32'd0);
    check("rst_state", 32'(state_o), 32'(ST_IDLE));
    reset = 1'b0;
    exp_last = SERVED_WRITE;

    // Read of a preloaded word.
    run_access(1'b0, CR_ADDR, '0);

    // Write then read back; strobe and drive window lengths.
    s0 = n_we_low;
    s1 = n_dq_oe;
    run_access(1'b1, 13'h0FF, 16'h1234);
    check("we_n_low_cycles", 32'(n_we_low - s0), 32'(WC));
    check("dq_oe_cycles", 32'(n_dq_oe - s1), 32'(WC + 2));
    run_access(1'b0, 13'h0FF, '0);

    // Out-of-range accesses never strobe the SRAM.
    s0 = n_ce_fall;
    s1 = n_rd_rdy;
    s2 = n_wr_rdy;
    run_access(1'b0, 13'd4096, '0);
    run_access(1'b1, 13'h1FFF, 16'hAAAA);
    check("invalid_ce_fall", 32'(n_ce_fall - s0), 32'd0);
    check("invalid_read_ready", 32'(n_rd_rdy - s1), 32'd0);
    check("invalid_write_ready", 32'(n_wr_rdy - s2), 32'd0);

    // Request held through the response cycle is served once.
    s0 = n_ce_fall;
    s1 = n_rd_rdy;
    run_access(1'b0, CR_ADDR, '0);
    repeat (4) @(posedge clk);
    #1;
    check("single_access_ce_fall", 32'(n_ce_fall - s0), 32'd1);
    check("single_access_ready", 32'(n_rd_rdy - s1), 32'd1);

    // Simultaneous requests.
    run_contend(4);
    repeat (2) @(posedge clk);
    #1;

    // Random valid traffic.
    for (int k = 0; k < 16; k++) begin
      run_access(1'($urandom_range(0, 1)), AW'($urandom_range(256, CAP - 1)), DW'($urandom));
    end

    // Reset during the write strobe aborts without a completion.
    s0 = n_wr_rdy;
    bus.req_sram_write_addr = 13'h0AA;
    bus.data_to_sram = 16'h5555;
    bus.req_sram_write = 1'b1;
    t = 0;
    while (state_o != ST_WRITE_STROBE && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("reached_write_strobe", 32'(state_o), 32'(ST_WRITE_STROBE));
    reset = 1'b1;
    bus.req_sram_write = 1'b0;
    @(posedge clk); #1;
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ce_n", 32'(sram_ce_n), 32'd1);
    reset = 1'b0;
    exp_last = SERVED_WRITE;
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_write_ready", 32'(n_wr_rdy - s0), 32'd0);

    // Controller still works after the abort.
    run_access(1'b0, 13'h0FF, '0);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(kind_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
